pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC width in bits.
REQ-002 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-003 SHALL have parameter BOOT_DELAY, default 2, meaning cycles spent in BOOT after reset release; legal range 1..15.
REQ-004 SHALL have parameter INC, default 4, meaning the sequential PC increment in bytes.
REQ-005 SHALL have port mp_clk_in, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port mp_rst_in, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port stall_in, input, 1, hold the PC this cycle.
REQ-008 SHALL have port branch_taken_in, input, 1, redirect the PC to branch_target_in.
REQ-009 SHALL have port branch_target_in, input, XLEN, the redirect address.
REQ-010 SHALL have port trap_in, input, 1, redirect the PC to trap_vec_in.
REQ-011 SHALL have port trap_vec_in, input, XLEN, the trap handler address.
REQ-012 SHALL have port halt_in, input, 1, request entry to HALT.
REQ-013 SHALL have port resume_in, input, 1, request exit from HALT.
REQ-014 SHALL have port pc_out, output, XLEN, the current fetch PC (registered).
REQ-015 SHALL have port pc_next_out, output, XLEN, pc_out+INC, combinational, modulo 2^XLEN.
REQ-016 SHALL have port pc_valid_out, output, 1, asserted when pc_out is a valid fetch address (state RUN).
REQ-017 SHALL have port misalign_out, output, 1, one-cycle pulse on a rejected misaligned branch.

Function
REQ-018 SHALL implement an FSM with states BOOT, RUN and HALT; pc_valid_out = (state==RUN).
REQ-019 In BOOT: a counter increments each cycle; on the edge where it equals BOOT_DELAY-1, go to RUN; pc_out holds BOOT_ADDR; all control inputs ignored.
REQ-020 In RUN, per-edge priority SHALL be trap > halt > branch > stall > sequential.
REQ-021 trap: pc_out <= trap_vec_in with bits[1:0] cleared; state stays RUN.
REQ-022 halt: state <= HALT; pc_out holds.
REQ-023 branch: pc_out <= branch_target_in; a branch with stall_in also high SHALL still redirect, so no redirect is lost.
REQ-024 stall: pc_out holds.
REQ-025 sequential: pc_out <= pc_out+INC, wrapping to 0 past 2^XLEN-1.
REQ-026 In HALT: trap -> RUN with the trap vector loaded; otherwise resume -> RUN with pc_out unchanged; trap+resume same cycle = trap; branch and stall ignored.
REQ-027 All redirects SHALL take effect on pc_out one edge after the request cycle; there are no bubbles inside the block.

Reset
REQ-028 On mp_rst_in low, immediately and regardless of clock: pc_out=BOOT_ADDR, state=BOOT, boot counter=0, pc_valid_out=0, misalign_out=0.
REQ-029 Reset asserted mid-operation (any state, any pending redirect) SHALL discard all pending actions; BOOT restarts after release.

Configuration
REQ-030 Macro PC_MISALIGN_CHK_EN defined: a RUN branch with branch_target_in[1:0]!=0 SHALL NOT be taken; pc_out <= trap_vec_in (bits[1:0] cleared), and misalign_out pulses high for exactly one cycle coincident with that pc_out.
REQ-031 Macro undefined: branch_target_in[1:0] SHALL be forced to 0 on load, and misalign_out SHALL be tied 0.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2-bit enum BOOT/RUN/HALT) and the default INC and BOOT_ADDR constants.
REQ-033 The boot-delay counter SHALL be a sub-module named pc_boot_cnt (input count limit, output done pulse).

Verification
REQ-034 Reset held 3 cycles, then released, BOOT_DELAY=2 -> pc_valid_out=0 for 2 edges, then 1; pc_out sequence 0x0, 0x4, 0x8.
REQ-035 In RUN at pc=0x100: stall_in=1 and branch_taken_in=1 with target 0x200 -> next pc_out=0x200; stall alone -> pc holds 0x200.
REQ-036 trap_in, halt_in and branch_taken_in asserted together, trap_vec_in=0x80 -> pc_out=0x80, state RUN, valid=1.
REQ-037 halt_in at pc=0x40 -> valid=0 and pc holds 0x40 for 5 cycles; resume_in -> valid=1, then 0x44.
REQ-038 PC_MISALIGN_CHK_EN defined, branch to 0x102, trap_vec 0x80 -> pc_out=0x80, misalign_out high for 1 cycle; macro undefined -> pc_out=0x100, misalign_out=0.
REQ-039 pc=0xFFFF_FFFC, sequential -> pc_out=0x0; async reset pulsed mid-cycle during HALT -> outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared definitions for the fetch PC unit.
//   pc_state_e       - 2-bit FSM encoding (BOOT / RUN / HALT)
//   PC_DEF_INC       - default sequential increment in bytes
//   PC_DEF_BOOT_ADDR - default PC value loaded at reset
//   pc_redirect_t    - one resolved redirect (target plus misalign flag)
package pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam int unsigned PC_DEF_INC       = 4;
    localparam logic [31:0] PC_DEF_BOOT_ADDR = 32'h0000_0000;

    typedef struct packed {
        logic        misalign;
        logic [31:0] target;
    } pc_redirect_t;

endpackage

// File: rtl/pc_boot_cnt.sv
// pc_boot_cnt: boot-delay counter.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - count while high; the count clears when en drops
//   limit      - terminal count
//   done       - combinational pulse on the cycle where count == limit
// The counter clears itself on done, so a later BOOT starts from zero.
module pc_boot_cnt #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic          done
);

    logic [CW-1:0] cnt;

    assign done = en && (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (done || !en)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with BOOT / RUN / HALT control.
//   mp_clk_in, mp_rst_in      - clock, asynchronous active-low reset
//   stall_in                  - hold the PC
//   branch_taken_in/target_in - redirect to branch_target_in
//   trap_in/trap_vec_in       - redirect to trap_vec_in (word aligned)
//   halt_in/resume_in         - enter / leave HALT
//   pc_out                    - registered fetch PC
//   pc_next_out               - pc_out + INC (combinational, wraps)
//   pc_valid_out              - high in RUN
//   misalign_out              - one-cycle pulse on a rejected misaligned branch
// Optional macro PC_MISALIGN_CHK_EN: a misaligned RUN branch is rejected and
// vectors to the trap address instead; without it the low target bits are
// simply cleared and misalign_out stays 0.
// RUN priority: trap > halt > branch > stall > sequential. A branch beats a
// stall so a redirect arriving during a stall is never dropped.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  BOOT_ADDR  = XLEN'(PC_DEF_BOOT_ADDR),
    parameter int unsigned      BOOT_DELAY = 2,   // legal range 1..15
    parameter int unsigned      INC        = PC_DEF_INC
) (
    input  logic            mp_clk_in,
    input  logic            mp_rst_in,
    input  logic            stall_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] branch_target_in,
    input  logic            trap_in,
    input  logic [XLEN-1:0] trap_vec_in,
    input  logic            halt_in,
    input  logic            resume_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next_out,
    output logic            pc_valid_out,
    output logic            misalign_out
);

    localparam logic [3:0]      BOOT_LIM   = 4'(BOOT_DELAY - 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    pc_state_e       state;
    logic [XLEN-1:0] pc_q;
    logic            boot_done;
    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] br_tgt;
    logic            br_bad;

    assign trap_tgt = trap_vec_in & ALIGN_MASK;
    assign br_tgt   = branch_target_in & ALIGN_MASK;

`ifdef PC_MISALIGN_CHK_EN
    assign br_bad = |(branch_target_in & ~ALIGN_MASK);
`else
    assign br_bad = 1'b0;
`endif

    pc_boot_cnt #(.CW(4)) u_boot_cnt (
        .clk   (mp_clk_in),
        .rst_n (mp_rst_in),
        .en    (state == ST_BOOT),
        .limit (BOOT_LIM),
        .done  (boot_done)
    );

    assign pc_out       = pc_q;
    assign pc_next_out  = pc_q + XLEN'(INC);
    assign pc_valid_out = (state == ST_RUN);

`ifdef PC_MISALIGN_CHK_EN
    logic misalign_q;
    assign misalign_out = misalign_q;
`else
    assign misalign_out = 1'b0;
`endif

    always_ff @(posedge mp_clk_in or negedge mp_rst_in) begin
        if (!mp_rst_in) begin
            state <= ST_BOOT;
            pc_q  <= BOOT_ADDR;
`ifdef PC_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
`ifdef PC_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                ST_BOOT: begin
                    pc_q <= BOOT_ADDR;
                    if (boot_done)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (trap_in) begin
                        pc_q <= trap_tgt;
                    end else if (halt_in) begin
                        state <= ST_HALT;
                    end else if (branch_taken_in) begin
                        if (br_bad) begin
                            pc_q <= trap_tgt;
`ifdef PC_MISALIGN_CHK_EN
                            misalign_q <= 1'b1;
`endif
                        end else begin
                            pc_q <= br_tgt;
                        end
                    end else if (!stall_in) begin
                        pc_q <= pc_next_out;
                    end
                end
                ST_HALT: begin
                    if (trap_in) begin
                        state <= ST_RUN;
                        pc_q  <= trap_tgt;
                    end else if (resume_in) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit (default parameters).
// A table of per-cycle vectors is driven on the falling edge; the expected
// result is pushed to a queue at drive time and popped and compared just
// after the following rising edge. Hand-written sequences cover reset.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br, trap, halt, resume;
    logic [31:0] tgt, tvec;
    logic [31:0] pc, pc_next;
    logic        valid, mis;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .mp_clk_in        (clk),
        .mp_rst_in        (rst_n),
        .stall_in         (stall),
        .branch_taken_in  (br),
        .branch_target_in (tgt),
        .trap_in          (trap),
        .trap_vec_in      (tvec),
        .halt_in          (halt),
        .resume_in        (resume),
        .pc_out           (pc),
        .pc_next_out      (pc_next),
        .pc_valid_out     (valid),
        .misalign_out     (mis)
    );

    typedef struct {
        string       name;
        logic        s, b, tr, h, r;
        logic [31:0] t, tv;
        logic [31:0] epc;
        logic        ev, em;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(string n, logic s, logic b, logic [31:0] t,
                                logic tr, logic [31:0] tv, logic h, logic r,
                                logic [31:0] epc, logic ev, logic em);
        vec_t v;
        v.name = n; v.s = s; v.b = b; v.t = t; v.tr = tr; v.tv = tv;
        v.h = h; v.r = r; v.epc = epc; v.ev = ev; v.em = em;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    endtask

    task automatic drive_idle();
        stall = 0; br = 0; trap = 0; halt = 0; resume = 0;
        tgt = '0; tvec = '0;
    endtask

    // Called at a falling edge: drive, wait one rising edge, compare, return
    // at the next falling edge.
    task automatic apply(vec_t v);
        vec_t e;
        stall = v.s; br = v.b; tgt = v.t; trap = v.tr; tvec = v.tv;
        halt = v.h; resume = v.r;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.name, ".pc"},      pc,            e.epc);
        chk({e.name, ".pc_next"}, pc_next,       e.epc + 32'd4);
        chk({e.name, ".valid"},   {31'd0, valid}, {31'd0, e.ev});
        chk({e.name, ".mis"},     {31'd0, mis},   {31'd0, e.em});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mis_pc, mis_next;
        logic        mis_flag;
`ifdef PC_MISALIGN_CHK_EN
        mis_pc = 32'h80;  mis_next = 32'h84;  mis_flag = 1'b1;
`else
        mis_pc = 32'h100; mis_next = 32'h104; mis_flag = 1'b0;
`endif
        //            name          s  b  tgt            tr tvec      h  r  exp_pc          v  m
        vecs.push_back(mk("boot_ign",  0, 1, 32'h10,       1, 32'h80,   1, 0, 32'h0,          0, 0));
        vecs.push_back(mk("boot_end",  0, 0, 0,            0, 0,        0, 0, 32'h0,          1, 0));
        vecs.push_back(mk("seq4",      0, 0, 0,            0, 0,        0, 0, 32'h4,          1, 0));
        vecs.push_back(mk("seq8",      0, 0, 0,            0, 0,        0, 0, 32'h8,          1, 0));
        vecs.push_back(mk("br100",     0, 1, 32'h100,      0, 0,        0, 0, 32'h100,        1, 0));
        vecs.push_back(mk("stall_br",  1, 1, 32'h200,      0, 0,        0, 0, 32'h200,        1, 0));
        vecs.push_back(mk("stall",     1, 0, 0,            0, 0,        0, 0, 32'h200,        1, 0));
        vecs.push_back(mk("seq204",    0, 0, 0,            0, 0,        0, 0, 32'h204,        1, 0));
        vecs.push_back(mk("trap_all",  0, 1, 32'h300,      1, 32'h80,   1, 0, 32'h80,         1, 0));
        vecs.push_back(mk("trap_clr",  0, 0, 0,            1, 32'h83,   0, 0, 32'h80,         1, 0));
        vecs.push_back(mk("br40",      0, 1, 32'h40,       0, 0,        0, 0, 32'h40,         1, 0));
        vecs.push_back(mk("halt",      0, 0, 0,            0, 0,        1, 0, 32'h40,         0, 0));
        vecs.push_back(mk("halt_br",   0, 1, 32'h500,      0, 0,        0, 0, 32'h40,         0, 0));
        vecs.push_back(mk("halt_stl",  1, 0, 0,            0, 0,        0, 0, 32'h40,         0, 0));
        vecs.push_back(mk("halt_w1",   0, 0, 0,            0, 0,        0, 0, 32'h40,         0, 0));
        vecs.push_back(mk("halt_w2",   0, 0, 0,            0, 0,        0, 0, 32'h40,         0, 0));
        vecs.push_back(mk("resume",    0, 0, 0,            0, 0,        0, 1, 32'h40,         1, 0));
        vecs.push_back(mk("seq44",     0, 0, 0,            0, 0,        0, 0, 32'h44,         1, 0));
        vecs.push_back(mk("run_res",   0, 0, 0,            0, 0,        0, 1, 32'h48,         1, 0));
        vecs.push_back(mk("halt2",     0, 0, 0,            0, 0,        1, 0, 32'h48,         0, 0));
        vecs.push_back(mk("trap_res",  0, 0, 0,            1, 32'h90,   0, 1, 32'h90,         1, 0));
        vecs.push_back(mk("br100b",    0, 1, 32'h100,      0, 0,        0, 0, 32'h100,        1, 0));
        vecs.push_back(mk("br_mis",    0, 1, 32'h102,      0, 32'h80,   0, 0, mis_pc,         1, mis_flag));
        vecs.push_back(mk("after_mis", 0, 0, 0,            0, 0,        0, 0, mis_next,       1, 0));
        vecs.push_back(mk("br_top",    0, 1, 32'hFFFF_FFFC,0, 0,        0, 0, 32'hFFFF_FFFC,  1, 0));
        vecs.push_back(mk("wrap",      0, 0, 0,            0, 0,        0, 0, 32'h0,          1, 0));
        vecs.push_back(mk("seq_w4",    0, 0, 0,            0, 0,        0, 0, 32'h4,          1, 0));
        vecs.push_back(mk("halt3",     0, 0, 0,            0, 0,        1, 0, 32'h4,          0, 0));

        // Power-on reset: outputs must be at reset values before any edge.
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk("rst.pc",    pc,             32'h0);
        chk("rst.valid", {31'd0, valid}, 32'd0);
        chk("rst.mis",   {31'd0, mis},   32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset mid-cycle while halted at pc=0x4, with a branch
        // pending: outputs must clear without a clock edge.
        #2;
        rst_n = 1'b0;
        br = 1'b1; tgt = 32'h700;
        #1;
        chk("async.pc",    pc,             32'h0);
        chk("async.valid", {31'd0, valid}, 32'd0);
        chk("async.mis",   {31'd0, mis},   32'd0);
        @(posedge clk);
        #1;
        chk("async_hold.pc", pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // BOOT restarts from zero; the pending branch is ignored throughout.
        apply(mk("reboot1", 0, 1, 32'h700, 0, 0, 0, 0, 32'h0, 0, 0));
        apply(mk("reboot2", 0, 1, 32'h700, 0, 0, 0, 0, 32'h0, 1, 0));
        apply(mk("reboot3", 0, 0, 0,       0, 0, 0, 0, 32'h4, 1, 0));

        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
